// File: rtl/fifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared helpers for both pointer domains of the async FIFO.
//                - bin2gray / gray2bin conversions on a wide pointer word.
//                  Callers zero-extend their pointer into the word and
//                  size-cast the result back to their own width.
//                - fifo_depth(): FIFO depth implied by a pointer width that
//                  includes the wrap bit.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Widest pointer the helpers support. Narrower pointers are carried in
    // the low bits with zeros above them.
    localparam int c_ptr_max_w = 32;

    typedef logic [c_ptr_max_w-1:0] ptr_word_t;

    // Binary to reflected Gray code.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above
    // it. Doubling shift distances build that prefix XOR in log2 steps. The
    // zero-extension above the caller's width leaves the result unaffected.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin = gray;
        for (int s = 1; s < c_ptr_max_w; s = s * 2) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

    // The top pointer bit is the wrap bit, so only pwidth-1 bits address RAM.
    function automatic int fifo_depth(input int pwidth);
        return 1 << (pwidth - 1);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/gray_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gray_sync
//  Description : Multi-flop synchroniser for a Gray-coded pointer crossing
//                into the clk domain. It is a plain flop chain with no logic
//                between stages. Because the source changes at most one bit
//                per source clock, the captured word is always either the old
//                or the new pointer value.
//  Ports       : clk    in   1      destination-domain clock
//                rst_n  in   1      async active-low reset, clears all stages
//                d      in   width  Gray pointer from the other clock domain
//                q      out  width  synchronised pointer (last stage)
//  Revision    : 1.0  initial release
// ============================================================================
module gray_sync #(
    parameter int width       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[SYNC_STAGES-1];

endmodule : gray_sync
`default_nettype wire

// File: rtl/write_pointer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : write_pointer
//  Description : Write-domain pointer and flag controller of the async FIFO.
//                It owns the binary write pointer (RAM address) and the Gray
//                write pointer exported to the read domain. It synchronises
//                the read domain's Gray pointer into w_clk and derives
//                registered full, almost_full and fill level from it. It also
//                keeps a sticky overflow flag.
//  Ports       : w_clk        in   1       write-domain clock
//                w_rst        in   1       async active-low reset
//                w_en         in   1       write request from producer
//                g_rptr       in   pwidth  Gray read pointer (async to w_clk)
//                w_ack        out  1       w_en & ~full, RAM write enable
//                b_wptr       out  pwidth  binary write pointer
//                g_wptr       out  pwidth  registered Gray write pointer
//                full         out  1       registered full flag
//                almost_full  out  1       registered, level >= AF_LEVEL
//                w_level      out  pwidth  registered fill level, 0..depth
//                overflow     out  1       sticky write-while-full flag
//  Revision    : 1.0  initial release
// ============================================================================
module write_pointer
    import fifo_pkg::*;
#(
    parameter int pwidth      = 4,
    parameter int AF_LEVEL    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_en,
    input  logic [pwidth-1:0] g_rptr,
    output logic              w_ack,
    output logic [pwidth-1:0] b_wptr,
    output logic [pwidth-1:0] g_wptr,
    output logic              full,
    output logic              almost_full,
    output logic [pwidth-1:0] w_level,
    output logic              overflow
);

    localparam int                c_depth    = fifo_depth(pwidth);
    // AF_LEVEL never exceeds c_depth, and c_depth fits in pwidth bits.
    localparam logic [pwidth-1:0] c_af_level = pwidth'(AF_LEVEL);

    // ------------------------------------------------------------------
    // Read pointer brought into the write domain
    // ------------------------------------------------------------------
    logic [pwidth-1:0] w_rq;      // synchronised Gray read pointer
    logic [pwidth-1:0] w_rbin;    // same pointer in binary

    gray_sync #(
        .width       (pwidth),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (w_clk),
        .rst_n (w_rst),
        .d     (g_rptr),
        .q     (w_rq)
    );

    assign w_rbin = pwidth'(gray2bin(ptr_word_t'(w_rq)));

    // ------------------------------------------------------------------
    // Next-state pointer and flag terms
    // ------------------------------------------------------------------
    logic [pwidth-1:0] w_b_next;
    logic [pwidth-1:0] w_g_next;
    logic [pwidth-1:0] w_full_gray;   // Gray value of the write pointer at full
    logic [pwidth-1:0] w_level_next;
    logic              w_full_next;
    logic              w_af_next;

    // full is registered from the post-write pointer, so it is already
    // asserted on the cycle after the last free slot is taken. That lets
    // w_ack use it directly and no write past full is ever accepted.
    assign w_ack = w_en & ~full;

    // The natural modulo-2**pwidth wrap is what the wrap bit relies on.
    assign w_b_next = b_wptr + {{(pwidth-1){1'b0}}, w_ack};
    assign w_g_next = pwidth'(bin2gray(ptr_word_t'(w_b_next)));

    // The write pointer is a full lap ahead of the read pointer when the
    // binary values differ only in the wrap bit. In Gray code that is the
    // top two bits inverted with the rest equal.
    assign w_full_gray = {~w_rq[pwidth-1:pwidth-2], w_rq[pwidth-3:0]};
    assign w_full_next = (w_g_next == w_full_gray);

    // The modulo subtract gives the occupancy even when either pointer has
    // wrapped. The level lags read releases by the synchroniser depth, so
    // it may overstate the occupancy but never understate it.
    assign w_level_next = w_b_next - w_rbin;
    assign w_af_next    = (w_level_next >= c_af_level);

    // ------------------------------------------------------------------
    // Pointer and flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            w_level     <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= w_b_next;
            g_wptr      <= w_g_next;
            full        <= w_full_next;
            almost_full <= w_af_next;
            w_level     <= w_level_next;
            // Sticky record of a request refused because the FIFO was full.
            overflow    <= overflow | (w_en & full);
        end
    end

endmodule : write_pointer
`default_nettype wire
